// File: rtl/car_pkg.sv
// Shared types and widths for the player-car controller.
// Build option: CAR_CTL_BOOST_EN widens speed and adds a boost button.
package car_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CRASH = 2'd2
    } state_t;

`ifdef CAR_CTL_BOOST_EN
    localparam int SPEED_W = 5;
    localparam int BTN_W   = 5;
`else
    localparam int SPEED_W = 4;
    localparam int BTN_W   = 4;
`endif

    // Signed working width for coordinates: 11-bit screen range plus a sign bit.
    localparam int COORD_W = 12;

    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_BOOST = 4;

endpackage

// File: rtl/car_ctl_if.sv
// Frame/button inputs and car position/status outputs of car_ctl.
// Build option: CAR_CTL_BOOST_EN adds btn_boost.
interface car_ctl_if;
    import car_pkg::*;

    logic               frame_ended;
    logic               enable;
    logic               btn_up;
    logic               btn_down;
    logic               btn_left;
    logic               btn_right;
`ifdef CAR_CTL_BOOST_EN
    logic               btn_boost;
`endif
    logic [10:0]        xpos;
    logic [10:0]        ypos;
    logic [SPEED_W-1:0] speed;
    logic [3:0]         lap_cnt;
    logic               crashed;

    modport master (
        output frame_ended, enable, btn_up, btn_down, btn_left, btn_right,
`ifdef CAR_CTL_BOOST_EN
        output btn_boost,
`endif
        input  xpos, ypos, speed, lap_cnt, crashed
    );

    modport slave (
        input  frame_ended, enable, btn_up, btn_down, btn_left, btn_right,
`ifdef CAR_CTL_BOOST_EN
        input  btn_boost,
`endif
        output xpos, ypos, speed, lap_cnt, crashed
    );

endinterface

// File: rtl/car_ctl_btn_sync.sv
// Parameterised-width two-flop synchronizer for asynchronous push buttons.
module btn_sync #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/car_ctl.sv
// Player-car motion controller: speed, steering, wall crash freeze and lap wrap, once per frame.
// Build option: CAR_CTL_BOOST_EN enables the boost button (double ceiling, +2 acceleration steps).
module car_ctl
    import car_pkg::*;
#(
    parameter int SCREEN_W     = 1024,
    parameter int SCREEN_H     = 768,
    parameter int CAR_W        = 64,
    parameter int CAR_H        = 64,
    parameter int X_START      = 480,
    parameter int Y_START      = 640,
    parameter int MAX_SPEED    = 8,
    parameter int ACC_FRAMES   = 4,
    parameter int COAST_FRAMES = 8,
    parameter int STEER_STEP   = 4,
    parameter int CRASH_FRAMES = 60
) (
    input  logic      pclk,
    input  logic      rst,
    car_ctl_if.slave  bus
);

    localparam int X_MAX   = SCREEN_W - CAR_W;
    localparam int Y_WRAP  = SCREEN_H - CAR_H;
    localparam int ACC_W   = (ACC_FRAMES   > 1) ? $clog2(ACC_FRAMES)   : 1;
    localparam int COAST_W = (COAST_FRAMES > 1) ? $clog2(COAST_FRAMES) : 1;
    localparam int CRASH_W = (CRASH_FRAMES > 1) ? $clog2(CRASH_FRAMES) : 1;

    logic [BTN_W-1:0] w_btn_raw;
    logic [BTN_W-1:0] w_btn;

`ifdef CAR_CTL_BOOST_EN
    assign w_btn_raw = {bus.btn_boost, bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};
`else
    assign w_btn_raw = {bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};
`endif

    btn_sync #(.W(BTN_W)) u_btn_sync (
        .clk   (pclk),
        .rst_n (rst),
        .i_d   (w_btn_raw),
        .o_q   (w_btn)
    );

    logic w_up, w_down, w_left, w_right;
    assign w_up    = w_btn[BTN_UP];
    assign w_down  = w_btn[BTN_DOWN];
    assign w_left  = w_btn[BTN_LEFT];
    assign w_right = w_btn[BTN_RIGHT];

    logic [SPEED_W-1:0] w_ceiling;
    logic [SPEED_W-1:0] w_step;
`ifdef CAR_CTL_BOOST_EN
    assign w_ceiling = w_btn[BTN_BOOST] ? SPEED_W'(2 * MAX_SPEED) : SPEED_W'(MAX_SPEED);
    assign w_step    = w_btn[BTN_BOOST] ? SPEED_W'(2) : SPEED_W'(1);
`else
    assign w_ceiling = SPEED_W'(MAX_SPEED);
    assign w_step    = SPEED_W'(1);
`endif

    state_t             r_state;
    logic [10:0]        r_xpos;
    logic [10:0]        r_ypos;
    logic [SPEED_W-1:0] r_speed;
    logic [3:0]         r_lap;
    logic               r_crashed;
    logic [ACC_W-1:0]   r_acc_cnt;
    logic [COAST_W-1:0] r_coast_cnt;
    logic [CRASH_W-1:0] r_crash_cnt;

    logic [SPEED_W-1:0] w_spd_next;
    logic [SPEED_W:0]   w_spd_sum;
    logic [ACC_W-1:0]   w_acc_next;
    logic [COAST_W-1:0] w_coast_next;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_spd_next   = r_speed;
        w_spd_sum    = '0;
        w_acc_next   = r_acc_cnt;
        w_coast_next = r_coast_cnt;
        if (w_down) begin
            w_spd_next   = (r_speed > SPEED_W'(2)) ? r_speed - SPEED_W'(2) : '0;
            w_acc_next   = '0;
            w_coast_next = '0;
        end else if (w_up) begin
            w_coast_next = '0;
            if (r_acc_cnt == ACC_W'(ACC_FRAMES - 1)) begin
                w_acc_next = '0;
                w_spd_sum  = {1'b0, r_speed} + {1'b0, w_step};
                w_spd_next = (w_spd_sum > {1'b0, w_ceiling}) ? w_ceiling : w_spd_sum[SPEED_W-1:0];
            end else begin
                w_acc_next = r_acc_cnt + ACC_W'(1);
            end
        end else begin
            w_acc_next = '0;
            if (r_coast_cnt == COAST_W'(COAST_FRAMES - 1)) begin
                w_coast_next = '0;
                w_spd_next   = (r_speed != '0) ? r_speed - SPEED_W'(1) : '0;
            end else begin
                w_coast_next = r_coast_cnt + COAST_W'(1);
            end
        end
        // Releasing boost pulls an over-ceiling speed back down in one frame.
        if (w_spd_next > w_ceiling) begin
            w_spd_next = w_ceiling;
        end
    end

    logic [COORD_W-1:0] w_y_n;
    logic [COORD_W-1:0] w_y_wrap;
    logic [COORD_W-1:0] w_x_n;
    logic               w_steer;
    logic               w_x_neg;
    logic               w_x_over;

    assign w_y_n    = {1'b0, r_ypos} - COORD_W'(w_spd_next);
    assign w_y_wrap = w_y_n + COORD_W'(Y_WRAP);
    assign w_steer  = (w_left ^ w_right) && (w_spd_next != '0);
    assign w_x_n    = w_left ? ({1'b0, r_xpos} - COORD_W'(STEER_STEP))
                             : ({1'b0, r_xpos} + COORD_W'(STEER_STEP));
    assign w_x_neg  = w_x_n[COORD_W-1];
    assign w_x_over = !w_x_neg && (w_x_n > COORD_W'(X_MAX));

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_xpos      <= 11'(X_START);
            r_ypos      <= 11'(Y_START);
            r_speed     <= '0;
            r_lap       <= '0;
            r_crashed   <= 1'b0;
            r_acc_cnt   <= '0;
            r_coast_cnt <= '0;
            r_crash_cnt <= '0;
        end else if (bus.frame_ended) begin
            if (!bus.enable) begin
                r_state     <= IDLE;
                r_xpos      <= 11'(X_START);
                r_ypos      <= 11'(Y_START);
                r_speed     <= '0;
                r_crashed   <= 1'b0;
                r_acc_cnt   <= '0;
                r_coast_cnt <= '0;
                r_crash_cnt <= '0;
            end else begin
                case (r_state)
                    IDLE: r_state <= RUN;
                    RUN: begin
                        r_speed     <= w_spd_next;
                        r_acc_cnt   <= w_acc_next;
                        r_coast_cnt <= w_coast_next;
                        if (w_y_n[COORD_W-1]) begin
                            r_ypos <= w_y_wrap[10:0];
                            r_lap  <= r_lap + 4'd1;
                        end else begin
                            r_ypos <= w_y_n[10:0];
                        end
                        if (w_steer) begin
                            if (w_x_neg || w_x_over) begin
                                r_xpos      <= w_x_neg ? 11'd0 : 11'(X_MAX);
                                r_speed     <= '0;
                                r_acc_cnt   <= '0;
                                r_coast_cnt <= '0;
                                r_crash_cnt <= '0;
                                r_crashed   <= 1'b1;
                                r_state     <= CRASH;
                            end else begin
                                r_xpos <= w_x_n[10:0];
                            end
                        end
                    end
                    CRASH: begin
                        if (r_crash_cnt == CRASH_W'(CRASH_FRAMES - 1)) begin
                            r_crash_cnt <= '0;
                            r_crashed   <= 1'b0;
                            r_state     <= RUN;
                        end else begin
                            r_crash_cnt <= r_crash_cnt + CRASH_W'(1);
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign bus.xpos    = r_xpos;
    assign bus.ypos    = r_ypos;
    assign bus.speed   = r_speed;
    assign bus.lap_cnt = r_lap;
    assign bus.crashed = r_crashed;

endmodule

// File: tb/tb_car_ctl.sv
// Directed plus randomized bench for car_ctl against a frame-level behavioural model.
module tb_car_ctl;

    logic pclk;
    logic rst;
    car_ctl_if bus ();

    car_ctl dut (
        .pclk (pclk),
        .rst  (rst),
        .bus  (bus)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: mode 0 = parked, 1 = driving, 2 = frozen after a wall hit.
    int m_x, m_y, m_spd, m_lap, m_mode, m_acc, m_coast, m_frozen;
    bit b_up, b_down, b_left, b_right;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".xpos"},    32'(bus.xpos),    32'(m_x));
        check({tag, ".ypos"},    32'(bus.ypos),    32'(m_y));
        check({tag, ".speed"},   32'(bus.speed),   32'(m_spd));
        check({tag, ".lap"},     32'(bus.lap_cnt), 32'(m_lap));
        check({tag, ".crashed"}, 32'(bus.crashed), (m_mode == 2) ? 32'd1 : 32'd0);
    endtask

    task automatic model_reset();
        m_x = 480; m_y = 640; m_spd = 0; m_lap = 0; m_mode = 0;
        m_acc = 0; m_coast = 0; m_frozen = 0;
    endtask

    task automatic model_pulse(input bit en);
        int nx;
        if (!en) begin
            m_mode = 0; m_x = 480; m_y = 640; m_spd = 0;
            m_acc = 0; m_coast = 0; m_frozen = 0;
            return;
        end
        case (m_mode)
            0: m_mode = 1;
            1: begin
                if (b_down) begin
                    m_spd = (m_spd >= 2) ? m_spd - 2 : 0;
                    m_acc = 0; m_coast = 0;
                end else if (b_up) begin
                    m_coast = 0;
                    m_acc++;
                    if (m_acc == 4) begin
                        m_acc = 0;
                        if (m_spd < 8) m_spd++;
                    end
                end else begin
                    m_acc = 0;
                    m_coast++;
                    if (m_coast == 8) begin
                        m_coast = 0;
                        if (m_spd > 0) m_spd--;
                    end
                end
                m_y = m_y - m_spd;
                if (m_y < 0) begin
                    m_y   = m_y + 704;
                    m_lap = (m_lap + 1) % 16;
                end
                if ((b_left != b_right) && m_spd > 0) begin
                    nx = b_left ? m_x - 4 : m_x + 4;
                    if (nx < 0 || nx > 960) begin
                        m_x = (nx < 0) ? 0 : 960;
                        m_spd = 0; m_acc = 0; m_coast = 0; m_frozen = 0;
                        m_mode = 2;
                    end else begin
                        m_x = nx;
                    end
                end
            end
            default: begin
                m_frozen++;
                if (m_frozen == 60) begin
                    m_frozen = 0;
                    m_mode = 1;
                end
            end
        endcase
    endtask

    task automatic set_btn(input bit u, input bit d, input bit l, input bit r);
        b_up = u; b_down = d; b_left = l; b_right = r;
        bus.btn_up = u; bus.btn_down = d; bus.btn_left = l; bus.btn_right = r;
    endtask

    // Gives the synchronizer time to settle, fires one frame pulse, samples on the falling edge.
    task automatic do_pulse();
        repeat (3) @(negedge pclk);
        bus.frame_ended = 1'b1;
        @(negedge pclk);
        bus.frame_ended = 1'b0;
        model_pulse(bus.enable);
    endtask

    initial begin
        #10ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        int x_exp;
        int frozen_pulses;

        rst = 1'b0;
        bus.frame_ended = 1'b0;
        bus.enable = 1'b0;
`ifdef CAR_CTL_BOOST_EN
        bus.btn_boost = 1'b0;
`endif
        set_btn(0, 0, 0, 0);
        model_reset();
        repeat (3) @(negedge pclk);
        check_all("reset");

        bus.enable = 1'b1;
        set_btn(1, 0, 0, 0);
        repeat (3) @(negedge pclk);
        bus.frame_ended = 1'b1;
        @(negedge pclk);
        bus.frame_ended = 1'b0;
        check_all("pulse_in_reset");

        rst = 1'b1;
        set_btn(0, 0, 0, 0);
        @(negedge pclk);
        do_pulse();
        check_all("enter_run");

        set_btn(1, 0, 0, 0);
        for (int i = 0; i < 40; i++) begin
            do_pulse();
            check_all("accel");
        end
        check("speed_saturated", 32'(bus.speed), 32'd8);

        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            do_pulse();
            check_all("lap_run");
            if (m_lap == 1) seen = 1'b1;
        end
        check("lap_seen", 32'(bus.lap_cnt), 32'd1);

        set_btn(1, 0, 1, 0);
        for (int i = 0; i < 300 && m_mode != 2; i++) begin
            do_pulse();
            check_all("steer_left");
        end
        check("left_wall.crashed", 32'(bus.crashed), 32'd1);
        check("left_wall.xpos",    32'(bus.xpos),    32'd0);
        check("left_wall.speed",   32'(bus.speed),   32'd0);

        set_btn(1, 0, 0, 1);
        frozen_pulses = 0;
        for (int i = 0; i < 70 && bus.crashed; i++) begin
            do_pulse();
            frozen_pulses++;
            check_all("frozen");
        end
        check("freeze_length", 32'(frozen_pulses), 32'd60);

        set_btn(1, 0, 0, 0);
        for (int i = 0; i < 40 && m_spd != 5; i++) begin
            do_pulse();
            check_all("reach5");
        end
        set_btn(1, 1, 0, 0);
        do_pulse();
        check_all("up_and_down");
        check("up_and_down.speed", 32'(bus.speed), 32'd3);

        set_btn(0, 0, 1, 1);
        x_exp = m_x;
        do_pulse();
        check_all("left_and_right");
        check("left_and_right.xpos", 32'(bus.xpos), 32'(x_exp));

        set_btn(1, 0, 0, 1);
        for (int i = 0; i < 400 && m_mode != 2; i++) begin
            do_pulse();
            check_all("steer_right");
        end
        check("right_wall.xpos", 32'(bus.xpos), 32'd960);

        bus.enable = 1'b0;
        do_pulse();
        check_all("disable");
        bus.enable = 1'b1;
        do_pulse();
        check_all("reenable");

        for (int i = 0; i < 300; i++) begin
            set_btn(($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 2),
                    1'($urandom), 1'($urandom));
            bus.enable = ($urandom_range(0, 19) != 0);
            do_pulse();
            check_all("random");
        end

        bus.enable = 1'b1;
        set_btn(1, 0, 0, 0);
        for (int i = 0; i < 200 && !(m_mode == 1 && m_spd == 6); i++) begin
            do_pulse();
            check_all("reach6");
        end
        check("before_reset.speed", 32'(bus.speed), 32'd6);
        repeat (2) @(negedge pclk);
        rst = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        @(negedge pclk);
        bus.frame_ended = 1'b1;
        @(negedge pclk);
        bus.frame_ended = 1'b0;
        check_all("reset_held");
        rst = 1'b1;
        do_pulse();
        check_all("after_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
